// File: rtl/vlane_pkg.sv
// Shared types and constants for the vector-lane CLA adder.
//   sew_e       : element width selector (8/16/32-bit elements per 32-bit lane)
//   LANE_W      : lane width in bits
//   NUM_BYTES   : byte lanes per lane (one carry/overflow flag per byte)
//   decode_sew  : maps the raw 2-bit sew field onto sew_e (reserved 11 -> 32-bit)
//   elem_bytes  : element width in bytes for a given sew_e
package vlane_pkg;

    localparam int unsigned LANE_W    = 32;
    localparam int unsigned NUM_BYTES = 4;

    typedef enum logic [1:0] {
        SEW8  = 2'b00,
        SEW16 = 2'b01,
        SEW32 = 2'b10
    } sew_e;

    function automatic sew_e decode_sew(input logic [1:0] raw);
        case (raw)
            2'b00:   return SEW8;
            2'b01:   return SEW16;
            default: return SEW32;
        endcase
    endfunction

    function automatic int unsigned elem_bytes(input sew_e sew);
        case (sew)
            SEW8:    return 1;
            SEW16:   return 2;
            default: return 4;
        endcase
    endfunction

endpackage

// File: rtl/cla_group_gp.sv
// Group generate/propagate for one carry-lookahead group.
//   p, g : bitwise propagate/generate of the group (LSB first)
//   gg   : group generate  = OR_i g[i] & p[i+1..top]
//   pg   : group propagate = AND of p[]
module cla_group_gp #(
    parameter int unsigned GROUP_W = 4
) (
    input  logic [GROUP_W-1:0] p,
    input  logic [GROUP_W-1:0] g,
    output logic               gg,
    output logic               pg
);

    always_comb begin
        gg = 1'b0;
        pg = 1'b1;
        // Folding from the LSB upward multiplies each lower generate by all
        // propagates above it.
        for (int unsigned i = 0; i < GROUP_W; i++) begin
            gg = g[i] | (p[i] & gg);
            pg = pg & p[i];
        end
    end

endmodule

// File: rtl/vlane_cla_adder.sv
// Two-stage pipelined SIMD add/subtract for one 32-bit vector lane.
// Elements are 8, 16 or 32 bits wide (sew_i), chosen per beat.
// Stage 1 registers bitwise P/G and per-group G'/P'; stage 2 resolves the
// group carry chain (cut at element boundaries) and registers sum/carry.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   in_valid_i / in_ready_o : operand handshake (a_i, b_i, sub_i, sew_i)
//   out_valid_o/out_ready_i : result handshake (sum_o, cout_o[, ovf_o])
//   cout_o                  : carry-out at the top byte of each element
//                             (no-borrow flag on subtract), other bits 0
// Optional: define VLANE_CLA_OVF_EN to add ovf_o, signed overflow at the
// top byte of each element.
module vlane_cla_adder
    import vlane_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned GROUP_W = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DATA_W-1:0]    a_i,
    input  logic [DATA_W-1:0]    b_i,
    input  logic                 sub_i,
    input  logic [1:0]           sew_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATA_W-1:0]    sum_o,
    output logic [NUM_BYTES-1:0] cout_o
`ifdef VLANE_CLA_OVF_EN
    ,
    output logic [NUM_BYTES-1:0] ovf_o
`endif
);

    localparam int unsigned NUM_GROUPS = DATA_W / GROUP_W;

    // ---------------- stage 1: bitwise and group P/G ----------------
    logic [DATA_W-1:0]     b_eff, p_c, g_c;
    logic [NUM_GROUPS-1:0] gg_c, pg_c;

    assign b_eff = b_i ^ {DATA_W{sub_i}};
    assign p_c   = a_i ^ b_eff;
    assign g_c   = a_i & b_eff;

    for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_gp
        cla_group_gp #(.GROUP_W(GROUP_W)) u_gp (
            .p  (p_c[k*GROUP_W +: GROUP_W]),
            .g  (g_c[k*GROUP_W +: GROUP_W]),
            .gg (gg_c[k]),
            .pg (pg_c[k])
        );
    end

    logic                  s1_valid, s2_valid;
    logic [DATA_W-1:0]     s1_p, s1_g;
    logic [NUM_GROUPS-1:0] s1_gg, s1_pg;
    logic                  s1_sub;
    sew_e                  s1_sew;

    logic s1_en, s2_en;
    assign s2_en      = !s2_valid || out_ready_i;
    assign s1_en      = !s1_valid || s2_en;
    assign in_ready_o = s1_en;

    // ---------------- stage 2: carry resolution ----------------
    logic [DATA_W-1:0]     cin_bit;
    logic [NUM_GROUPS-1:0] gcin;
    logic [NUM_BYTES-1:0]  byte_co, top_byte;
    logic [DATA_W-1:0]     sum_c;
    logic [NUM_BYTES-1:0]  cout_c;
`ifdef VLANE_CLA_OVF_EN
    logic [NUM_BYTES-1:0]  byte_ci7, ovf_c, ovf_q;
`endif

    always_comb begin
        logic chain;
        logic c;
        cin_bit  = '0;
        gcin     = '0;
        byte_co  = '0;
        top_byte = '0;
`ifdef VLANE_CLA_OVF_EN
        byte_ci7 = '0;
`endif
        // Group-level lookahead: the chain restarts with sub at each group
        // that begins a new element, so carries never cross elements.
        chain = s1_sub;
        for (int unsigned k = 0; k < NUM_GROUPS; k++) begin
            if (((k * GROUP_W) % (8 * elem_bytes(s1_sew))) == 0)
                chain = s1_sub;
            gcin[k] = chain;
            chain   = s1_gg[k] | (s1_pg[k] & chain);
        end
        // Bit carries inside each group ripple from the group carry-in.
        c = 1'b0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if ((i % GROUP_W) == 0)
                c = gcin[i / GROUP_W];
            cin_bit[i] = c;
`ifdef VLANE_CLA_OVF_EN
            if ((i % 8) == 7)
                byte_ci7[i / 8] = c;
`endif
            c = s1_g[i] | (s1_p[i] & c);
            if ((i % 8) == 7)
                byte_co[i / 8] = c;
        end
        for (int unsigned b = 0; b < NUM_BYTES; b++)
            top_byte[b] = (((b + 1) % elem_bytes(s1_sew)) == 0);
    end

    assign sum_c  = s1_p ^ cin_bit;
    assign cout_c = byte_co & top_byte;
`ifdef VLANE_CLA_OVF_EN
    assign ovf_c  = (byte_ci7 ^ byte_co) & top_byte;
`endif

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            sum_o    <= '0;
            cout_o   <= '0;
`ifdef VLANE_CLA_OVF_EN
            ovf_q    <= '0;
`endif
        end else begin
            if (s1_en) begin
                s1_valid <= in_valid_i;
                if (in_valid_i) begin
                    s1_p   <= p_c;
                    s1_g   <= g_c;
                    s1_gg  <= gg_c;
                    s1_pg  <= pg_c;
                    s1_sub <= sub_i;
                    s1_sew <= decode_sew(sew_i);
                end
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    sum_o  <= sum_c;
                    cout_o <= cout_c;
`ifdef VLANE_CLA_OVF_EN
                    ovf_q  <= ovf_c;
`endif
                end
            end
        end
    end

    assign out_valid_o = s2_valid;
`ifdef VLANE_CLA_OVF_EN
    assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_vlane_cla_adder.sv
// Self-checking bench for vlane_cla_adder: directed vectors, backpressure,
// reset behaviour and a randomized scoreboard run against an element-wise
// arithmetic reference model.
module tb_vlane_cla_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] a, b;
    logic        sub;
    logic [1:0]  sew;
    logic        out_valid, out_ready;
    logic [31:0] sum;
    logic [3:0]  cout;
`ifdef VLANE_CLA_OVF_EN
    logic [3:0]  ovf;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vlane_cla_adder #(.DATA_W(32), .GROUP_W(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .sub_i       (sub),
        .sew_i       (sew),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .cout_o      (cout)
`ifdef VLANE_CLA_OVF_EN
        ,
        .ovf_o       (ovf)
`endif
    );

    typedef struct {
        logic [31:0] s;
        logic [3:0]  c;
        logic [3:0]  v;
    } exp_t;

    // Element-wise reference: plain integer add/subtract per element.
    function automatic exp_t model(input logic [31:0] ma_in, input logic [31:0] mb_in,
                                   input logic msub, input logic [1:0] msew);
        exp_t r;
        int unsigned ew;
        longint unsigned mask, ea, eb, res, sa, sb, sr;
        int unsigned top;
        ew = (msew == 2'b00) ? 8 : (msew == 2'b01) ? 16 : 32;
        mask = (64'd1 << ew) - 64'd1;
        r.s = '0;
        r.c = '0;
        r.v = '0;
        for (int unsigned e = 0; e < 32 / ew; e++) begin
            ea = (longint'(ma_in) >> (e * ew)) & mask;
            eb = (longint'(mb_in) >> (e * ew)) & mask;
            if (msub) res = ea + ((~eb) & mask) + 64'd1;
            else      res = ea + eb;
            r.s = r.s | 32'((res & mask) << (e * ew));
            top = (e * ew + ew) / 8 - 1;
            if (msub) r.c[top] = (ea >= eb);
            else      r.c[top] = ((res >> ew) & 64'd1) != 0;
            sa = (ea >> (ew - 1)) & 64'd1;
            sb = (eb >> (ew - 1)) & 64'd1;
            sr = (res >> (ew - 1)) & 64'd1;
            if (msub) r.v[top] = (sa != sb) && (sr != sa);
            else      r.v[top] = (sa == sb) && (sr != sa);
        end
        return r;
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        sew = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++;
        if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h expected 00000000", sum); end
        checks++;
        if (cout !== 4'h0) begin errors++; $display("FAIL reset_cout: got %b expected 0000", cout); end
`ifdef VLANE_CLA_OVF_EN
        checks++;
        if (ovf !== 4'h0) begin errors++; $display("FAIL reset_ovf: got %b expected 0000", ovf); end
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [31:0] va [3] = '{32'h01FF7F80, 32'hFFFFFFFF, 32'h00050003};
        logic [31:0] vb [3] = '{32'h01010180, 32'h00000001, 32'h00010004};
        logic        vs [3] = '{1'b0, 1'b0, 1'b1};
        logic [1:0]  vw [3] = '{2'b00, 2'b10, 2'b01};
        logic [31:0] es [3] = '{32'h02008000, 32'h00000000, 32'h0004FFFF};
        logic [3:0]  ec [3] = '{4'b0101, 4'b1000, 4'b1000};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            a = va[i]; b = vb[i]; sub = vs[i]; sew = vw[i]; in_valid = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early: out_valid got %b expected 0", i, out_valid); end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_valid: got %b expected 1", i, out_valid); end
            checks++;
            if (sum !== es[i]) begin errors++; $display("FAIL dir%0d_sum: got %h expected %h", i, sum, es[i]); end
            checks++;
            if (cout !== ec[i]) begin errors++; $display("FAIL dir%0d_cout: got %b expected %b", i, cout, ec[i]); end
        end
        @(posedge clk);
        #1 idle_inputs();
    endtask

    task automatic test_backpressure();
        logic [31:0] ba [3];
        logic [31:0] bb [3];
        exp_t e [3];
        for (int i = 0; i < 3; i++) begin
            ba[i] = $urandom;
            bb[i] = $urandom;
            e[i]  = model(ba[i], bb[i], 1'b0, 2'b00);
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = ba[i]; b = bb[i]; sub = 1'b0; sew = 2'b00; in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== (i < 2)) begin errors++; $display("FAIL bp_ready%0d: got %b expected %b", i, in_ready, (i < 2)); end
            @(posedge clk);
            #1;
        end
        // Held output while stalled.
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || sum !== e[0].s || cout !== e[0].c) begin
            errors++; $display("FAIL bp_hold: got v=%b %h/%b expected v=1 %h/%b", out_valid, sum, cout, e[0].s, e[0].c);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        checks++;
        if (out_valid !== 1'b1 || sum !== e[0].s) begin errors++; $display("FAIL bp_out0: got v=%b %h expected v=1 %h", out_valid, sum, e[0].s); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || sum !== e[1].s || cout !== e[1].c) begin
            errors++; $display("FAIL bp_out1: got v=%b %h/%b expected v=1 %h/%b", out_valid, sum, cout, e[1].s, e[1].c);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || sum !== e[2].s || cout !== e[2].c) begin
            errors++; $display("FAIL bp_out2: got v=%b %h/%b expected v=1 %h/%b", out_valid, sum, cout, e[2].s, e[2].c);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
        @(posedge clk);
        #1 idle_inputs();
    endtask

    task automatic test_reset_midflight();
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = $urandom; b = $urandom; sub = 1'b0; sew = 2'b10; in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
        checks++;
        if (sum !== 32'h0 || cout !== 4'h0) begin errors++; $display("FAIL rstmid_data: got %h/%b expected 00000000/0000", sum, cout); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", in_ready); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale%0d: got %b expected 0", i, out_valid); end
        end
    endtask

`ifdef VLANE_CLA_OVF_EN
    task automatic test_ovf();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        a = 32'h0000007F; b = 32'h00000001; sub = 1'b0; sew = 2'b00; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || sum !== 32'h00000080) begin errors++; $display("FAIL ovf_sum: got v=%b %h expected v=1 00000080", out_valid, sum); end
        checks++;
        if (ovf !== 4'b0001) begin errors++; $display("FAIL ovf_flag: got %b expected 0001", ovf); end
        checks++;
        if (cout !== 4'b0000) begin errors++; $display("FAIL ovf_cout: got %b expected 0000", cout); end
        @(posedge clk);
        #1 idle_inputs();
    endtask
`endif

    task automatic test_random();
        localparam int N = 400;
        localparam int LIMIT = 4000;
        exp_t q [$];
        exp_t got_exp;
        int sent = 0;
        int recv = 0;
        int cyc = 0;
        logic prev_stall = 1'b0;
        logic [31:0] prev_sum = '0;
        logic [3:0]  prev_cout = '0;
        @(posedge clk);
        #1;
        while (recv < N && cyc < LIMIT) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < N) && ($urandom_range(0, 3) != 0);
            a   = $urandom;
            b   = $urandom;
            sub = $urandom_range(0, 1);
            sew = $urandom_range(0, 3);
            @(negedge clk);
            checks++;
            if (in_ready !== ((q.size() < 2) || out_ready)) begin
                errors++; $display("FAIL rnd_ready c%0d: got %b expected %b", cyc, in_ready, ((q.size() < 2) || out_ready));
            end
            if (prev_stall) begin
                checks++;
                if (sum !== prev_sum || cout !== prev_cout) begin
                    errors++; $display("FAIL rnd_hold c%0d: got %h/%b expected %h/%b", cyc, sum, cout, prev_sum, prev_cout);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rnd_spurious c%0d: got out_valid=1 expected 0 (nothing in flight)", cyc);
                end else begin
                    got_exp = q.pop_front();
                    recv++;
                    if (sum !== got_exp.s || cout !== got_exp.c) begin
                        errors++; $display("FAIL rnd_result c%0d: got %h/%b expected %h/%b", cyc, sum, cout, got_exp.s, got_exp.c);
                    end
`ifdef VLANE_CLA_OVF_EN
                    checks++;
                    if (ovf !== got_exp.v) begin errors++; $display("FAIL rnd_ovf c%0d: got %b expected %b", cyc, ovf, got_exp.v); end
`endif
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = sum;
            prev_cout  = cout;
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, sub, sew));
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (recv != N) begin errors++; $display("FAIL rnd_timeout: got %0d results expected %0d", recv, N); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midflight();
`ifdef VLANE_CLA_OVF_EN
        test_ovf();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vlane_cla_adder.md
VLANE_CLA_ADDER -- requirements
Module: vlane_cla_adder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, lane width in bits; legal value 32 only.
REQ-002 SHALL have parameter GROUP_W, default 4, lookahead group width in bits; SHALL divide 8.
REQ-003 SHALL have port clk_i, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid_i, input, 1, operand beat valid.
REQ-006 SHALL have port in_ready_o, output, 1, block accepts beat.
REQ-007 SHALL have port a_i, input, DATA_W, operand A.
REQ-008 SHALL have port b_i, input, DATA_W, operand B.
REQ-009 SHALL have port sub_i, input, 1, 1 selects A-B.
REQ-010 SHALL have port sew_i, input, 2, element width: 00 = 8, 01 = 16, 10 = 32, 11 = reserved, treated as 32.
REQ-011 SHALL have port out_valid_o, output, 1, result valid.
REQ-012 SHALL have port out_ready_i, input, 1, consumer accepts result.
REQ-013 SHALL have port sum_o, output, DATA_W, per-element sum/difference.
REQ-014 SHALL have port cout_o, output, 4, per-byte-lane carry-out; only the top byte of each element is meaningful; all other bits SHALL be 0.

Function
REQ-015 SHALL transfer a beat in when in_valid_i && in_ready_o, and out when out_valid_o && out_ready_i.
REQ-016 SHALL form B' = b_i XOR {DATA_W{sub_i}}; carry-in to every element LSB = sub_i.
REQ-017 Stage 1 SHALL register bitwise P = A^B' and G = A&B', plus per-group G'/P':
 - G' = OR over i of G[i]·P[i+1..top]
 - P' = AND of P[]
REQ-018 Stage 2 SHALL compute group carries from the registered G'/P':
 - chain cut at every element boundary selected by the registered sew
 - sum = P XOR carry vector
 - sum and cout registered into the output.
REQ-019 SHALL have latency of exactly 2 cycles, accept to out_valid_o, with no stall.
REQ-020 SHALL use the following stall logic:
 - s2_en = !s2_valid || out_ready_i
 - s1_en = !s1_valid || s2_en
 - in_ready_o = s1_en (combinational path from out_ready_i allowed).
REQ-021 SHALL sustain throughput of 1 beat/cycle when out_ready_i is held 1.
REQ-022 SHALL hold sum_o/cout_o stable while out_valid_o && !out_ready_i.
REQ-023 SHALL hold at most 2 beats in flight, preserving order; on a simultaneous output drain and input accept, both stages SHALL advance in the same cycle.
REQ-024 SHALL give sub cout as the no-borrow flag (1 = A >= B unsigned, per element).
REQ-025 SHALL latch sew_i and sub_i with the beat; sew_i may change every beat.

Reset
REQ-026 On rst_i, both stage valids SHALL clear next edge; out_valid_o = 0, sum_o = 0, cout_o = 0.
REQ-027 Reset mid-operation SHALL discard in-flight beats.
REQ-028 in_ready_o SHALL be 1 in the cycle after reset.

Configuration
REQ-029 With VLANE_CLA_OVF_EN defined:
 - SHALL add port ovf_o, output, 4: signed overflow at the top byte of each element, other bits 0
 - ovf_o SHALL be registered and reset like cout_o.
REQ-030 Without VLANE_CLA_OVF_EN, port ovf_o and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-031 Package vlane_pkg SHALL hold the sew_e enum (SEW8/SEW16/SEW32), the LANE_W = 32 constant and the NUM_BYTES = 4 constant.
REQ-032 Group G'/P' generation SHALL be a sub-module cla_group_gp, instantiated DATA_W/GROUP_W times.

Verification
REQ-033 SEW8 add, a=0x01FF7F80, b=0x01010180 -> sum_o=0x02008000, cout_o=4'b0101, after 2 cycles.
REQ-034 SEW32 add, a=0xFFFFFFFF, b=0x00000001 -> sum_o=0x00000000, cout_o=4'b1000.
REQ-035 SEW16 sub, a=0x00050003, b=0x00010004 -> sum_o=0x0004FFFF, cout_o=4'b1000.
REQ-036 Backpressure: out_ready_i=0, push 3 beats -> 2 accepted, in_ready_o=0 on the 3rd; release -> results in order, third accepted the same cycle as the first drains.
REQ-037 Assert rst_i with 2 beats in flight -> out_valid_o=0 next cycle, no stale result ever emitted.
REQ-038 With VLANE_CLA_OVF_EN, SEW8 add a=0x0000007F, b=0x00000001 -> sum_o=0x00000080, ovf_o=4'b0001, cout_o=0.
